// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit/receive FSM state encoding and 8N1 framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: power-of-two depth, wrapping pointers, occupancy counter, combinational head read.
module uart_tx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_send.sv
// UART 8N1 transmitter: byte FIFO in front of a start/data/stop framing FSM with a registered serial output.
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       dout
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    uart_state_e          state;
    uart_state_e          state_nxt;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [OCC_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 baud_done;
    logic                 load;
    logic                 shift_en;
    logic                 dout_nxt;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid),
        .pop   (load),
        .din   (data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready     = !fifo_full;
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign baud_done = (baud_cnt == CNT_W'(BIT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // load pops the FIFO head and starts a frame; shift_en presents the next data bit.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        dout_nxt  = dout;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = START;
                    load      = 1'b1;
                    dout_nxt  = START_BIT;
                end
            end
            START: begin
                if (baud_done) begin
                    state_nxt = DATA;
                    shift_en  = 1'b1;
                    dout_nxt  = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_nxt = STOP;
                        dout_nxt  = STOP_BIT;
                    end else begin
                        shift_en  = 1'b1;
                        dout_nxt  = shift_reg[0];
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        state_nxt = START;
                        load      = 1'b1;
                        dout_nxt  = START_BIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout     <= STOP_BIT;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            dout <= dout_nxt;
            if (state == IDLE || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (baud_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // The frame works from its own copy, so later changes on data cannot disturb it.
    always_ff @(posedge clk) begin
        if (load) begin
            shift_reg <= fifo_dout;
        end else if (shift_en) begin
            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
        end
    end

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send at BIT_CYC=16 with a bench-side serial receiver model for loopback checks.
module tb_uart_send;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 4;
    localparam int BIT_CYC  = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       busy;
    logic       dout;

    int n_cmp = 0;
    int n_err = 0;

    uart_send #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .data  (data),
        .ready (ready),
        .busy  (busy),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after the edge that launches the start bit; checks every cycle of all ten bits.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] f;
        logic       seen;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            seen = f[i];
            for (int j = 0; j < BIT_CYC; j++) begin
                if (dout !== f[i]) seen = dout;
                step(1);
            end
            check($sformatf("%s_bit%0d", tag, i), seen, f[i]);
        end
    endtask

    // Receiver model: find a start bit, sample mid-bit, return the byte.
    task automatic rx_byte(input string tag, output logic [7:0] b);
        int w;
        w = 0;
        b = 8'h00;
        while (dout !== 1'b0 && w < 400) begin
            step(1);
            w++;
        end
        if (w >= 400) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        step(BIT_CYC / 2);
        check({tag, "_start"}, dout, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(BIT_CYC);
            b[i] = dout;
        end
        step(BIT_CYC);
        check({tag, "_stop"}, dout, 1'b1);
    endtask

    task automatic idle_check(input string tag, input int n);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (dout !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            step(1);
        end
        check(tag, bad, 1'b0);
    endtask

    initial begin
        logic [7:0] rx;

        // Reset holds even while valid is offered.
        rst   = 1'b0;
        valid = 1'b1;
        data  = 8'hAA;
        step(3);
        check("rst_dout", dout, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b1);
        valid = 1'b0;
        rst   = 1'b1;
        step(2);
        check("post_rst_dout", dout, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        // Single byte 0x55.
        valid = 1'b1;
        data  = 8'h55;
        step(1);
        valid = 1'b0;
        data  = 8'hC3;
        check("single_wait_dout", dout, 1'b1);
        check("single_wait_busy", busy, 1'b1);
        step(1);
        check_frame(8'h55, "single");
        check("single_end_busy", busy, 1'b0);
        check("single_end_dout", dout, 1'b1);

        // Back-to-back 0xA3, 0x0F: second start directly after first stop.
        valid = 1'b1;
        data  = 8'hA3;
        step(1);
        data  = 8'h0F;
        step(1);
        valid = 1'b0;
        check("b2b_ready", ready, 1'b1);
        check_frame(8'hA3, "b2b_a3");
        check_frame(8'h0F, "b2b_0f");
        check("b2b_end_busy", busy, 1'b0);
        check("b2b_end_dout", dout, 1'b1);

        // Overflow: six writes, ready falls after the fifth.
        for (int k = 1; k <= 6; k++) begin
            valid = 1'b1;
            data  = 8'(k);
            step(1);
            check($sformatf("ovf_ready_w%0d", k), ready, (k >= 5) ? 1'b0 : 1'b1);
        end
        valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rx_byte($sformatf("ovf_rx%0d", k), rx);
            check($sformatf("ovf_byte%0d", k), rx, 8'(k));
        end
        step(BIT_CYC);
        idle_check("ovf_no_sixth", 300);

        // Full FIFO across the STOP->START edge: pop frees a slot for the next cycle.
        for (int k = 1; k <= 5; k++) begin
            valid = 1'b1;
            data  = 8'(k * 16);
            step(1);
        end
        valid = 1'b0;
        check("full_ready", ready, 1'b0);
        step(156);
        check("full_stop_dout", dout, 1'b1);
        check("full_stop_ready", ready, 1'b0);
        valid = 1'b1;
        data  = 8'h60;
        step(1);
        check("full_restart_dout", dout, 1'b0);
        check("full_after_pop_ready", ready, 1'b1);
        step(1);
        valid = 1'b0;
        check("full_refill_ready", ready, 1'b0);
        for (int k = 2; k <= 6; k++) begin
            rx_byte($sformatf("full_rx%0d", k), rx);
            check($sformatf("full_byte%0d", k), rx, 8'(k * 16));
        end
        step(BIT_CYC);
        idle_check("full_drained", 300);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        valid = 1'b1;
        data  = 8'hFF;
        step(1);
        data  = 8'h11;
        step(1);
        data  = 8'h22;
        step(1);
        valid = 1'b0;
        check("mid_busy", busy, 1'b1);
        step(70);
        check("mid_bit3_dout", dout, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_dout", dout, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", ready, 1'b1);
        step(3);

        // First byte after release is written on the first edge; loopback through the model.
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h39;
        step(1);
        valid = 1'b0;
        check("rel_busy", busy, 1'b1);
        check("rel_dout", dout, 1'b1);
        step(1);
        check("rel_start", dout, 1'b0);
        rx_byte("loop", rx);
        check("loop_byte", rx, 8'h39);
        step(BIT_CYC);
        idle_check("mid_queue_discarded", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
